td4_prog_loader: RTL
====================

# td4_prog_loader

Writable program memory for the TD4 core, with a UART loader. A host streams a framed 16-byte program over a serial line. The block checks the frame and commits it atomically into the 16×8 instruction store. The TD4 fetch port reads that store in place of the fixed ROM. While a frame is in flight, the block holds the CPU in reset so that it never executes a half-written program.

## Interface
- `CLKS_PER_BIT`, default 234: clk cycles per UART bit (27 MHz / 115200).
- `TIMEOUT_CLKS`, default 2700000: maximum idle clk cycles between bytes inside a frame (100 ms).
- `clk`, in, 1: system clock. This is the single clock domain.
- `rst`, in, 1: reset, synchronous and active-high.
- `uart_rx`, in, 1: serial input, 8N1, idle high, asynchronous to clk.
- `rd_addr`, in, 4: CPU fetch address.
- `rd_data`, out, 8: instruction at `rd_addr`. Combinational read.
- `cpu_hold`, out, 1: high while a frame is being received. The CPU's reset is driven from this signal.
- `load_done`, out, 1: one-cycle pulse on a successful commit.
- `load_err`, out, 1: sticky error flag.

## Operation
- **Input synchronizer:** `uart_rx` passes through a 2-FF synchronizer before any use.
- **UART receiver states:** R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE: a falling edge on the synchronized line enters R_START.
  - R_START: at cycle `CLKS_PER_BIT/2`, a high line is a glitch and returns to R_IDLE. A low line enters R_DATA.
  - R_DATA: 8 bits are sampled, LSB first, each `CLKS_PER_BIT` apart.
  - R_STOP: the stop bit is sampled mid-bit. High produces `byte_valid` for one cycle. Low produces `frame_err` for one cycle and the byte is discarded.
  - The receiver then returns to R_IDLE.
- **Frame format:** sync byte 0xA5, then 16 data bytes for addresses 0..15 in order, then a checksum byte.
  - A frame is valid when the 8-bit sum of the 16 data bytes plus the checksum byte equals 0x00 (mod 256).
- **Loader FSM states:** L_IDLE, L_DATA, L_CSUM.
  - L_IDLE: non-0xA5 bytes and framing errors are ignored. A 0xA5 byte clears `load_err`, clears the index and running sum, sets `cpu_hold`, and goes to L_DATA.
  - L_DATA: each byte is written to `stage[idx]`, added to the sum, and `idx` increments. After `idx`=15 the FSM goes to L_CSUM. A 0xA5 byte in this state is ordinary data.
  - L_CSUM: on the byte, if sum+byte == 0, all 16 stage entries are copied into `mem` in one cycle and `load_done` pulses. Otherwise `mem` is untouched and `load_err` is set. Either way the FSM returns to L_IDLE and `cpu_hold` is cleared.
- **Abort in L_DATA / L_CSUM:** a `frame_err`, or `TIMEOUT_CLKS` cycles with no `byte_valid`, sets `load_err`, clears `cpu_hold` and returns to L_IDLE. `mem` is untouched.
- **Memory integrity:** `mem` only ever holds a complete, checksum-verified program.
- **Widths:**
  - Sum: 8 bits, wraps.
  - `idx`: 4 bits.
  - Timeout counter: `$clog2(TIMEOUT_CLKS+1)` bits. It is cleared on every `byte_valid` and on entry to L_DATA.

## Timing
- **Reset values** (next clk edge with `rst`=1):
  - `mem` all 0x00; each 0x00 executes as add a,0, which is a NOP.
  - `cpu_hold`=0, `load_done`=0, `load_err`=0.
  - Both FSMs in idle; stage contents don't-care.
- **Reset mid-load:** the frame is discarded. The host must resend from the sync byte.
- **`byte_valid` timing:** `byte_valid` rises about 9.5 bit times plus 2 synchronizer cycles after the start edge.
  - `cpu_hold` rises on the cycle after `byte_valid` for 0xA5.
  - `load_done` / `load_err` are registered on the cycle after `byte_valid` for the checksum byte. `cpu_hold` falls on that same cycle.
  - `rd_data` reflects the new program on that same cycle.
- **`rd_data`:** tracks `rd_addr` with zero latency.
- **Simultaneous `byte_valid` and timeout expiry:** the byte wins and the counter resets.
- **Back-to-back frames:** a second sync byte may follow the checksum byte immediately.

## Test plan
- **Good frame.** `CLKS_PER_BIT`=8. Send 0xA5, 16×0xB1, 0xF0.
  - `cpu_hold` high during the frame, then `load_done` pulses once and `load_err`=0.
  - `rd_data`=0xB1 for every address.
- **Bad checksum.** Load the program above, then send 0xA5, 16×0x00, 0x01.
  - `load_err`=1 and no `load_done`.
  - `rd_data` is still 0xB1 for all addresses; `cpu_hold` returns to 0.
- **Framing error.** Send byte 5 of a frame with the stop bit driven 0.
  - Immediate abort: `load_err`=1, `cpu_hold`=0, `mem` unchanged.
  - A following correct frame commits and clears `load_err`.
- **Timeout.** `TIMEOUT_CLKS`=200. Send 0xA5 plus 3 data bytes, then idle.
  - `load_err`=1 exactly 200 cycles after the last `byte_valid`.
  - Late remaining bytes are ignored as non-sync bytes.
- **Leading garbage.** Send 0x12, 0x34, start-bit glitches of 2 cycles, then a valid knight-rider frame: B3 B6 BC B8 B8 BC B6 B3 B1 F0 00×6 plus its checksum.
  - Commit succeeds, with `rd_data`[9]=0xF0.
- **Reset mid-frame.** Assert `rst` for 1 cycle after 8 data bytes.
  - `mem` all 0x00, `cpu_hold`=0, `load_err`=0.
  - Remaining bytes cause no commit.

Source files
------------

// File: rtl/td4_prog_loader.sv
// TD4 writable program store with a UART frame loader.
// A framed 16-byte program (0xA5, 16 data bytes, checksum) is staged and
// committed into the 16x8 store in a single cycle only if the checksum holds.
// The CPU is held in reset for the duration of a frame.
module td4_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned TIMEOUT_CLKS = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {L_IDLE, L_DATA, L_CSUM} ld_state_e;

  // ---------------- input synchronizer ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- UART receiver ----------------
  rx_state_e     rstate_q, rstate_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q     <= R_IDLE;
      rcnt_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rstate_q     <= rstate_d;
      rcnt_q       <= rcnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Receiver next state: start-bit glitch rejection, LSB-first shift, stop check.
  always_comb begin
    rstate_d     = rstate_q;
    rcnt_d       = rcnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rstate_d = R_START;
      end
      R_START: begin
        if (rcnt_q == HALF_LAST) begin
          rcnt_d   = '0;
          bit_d    = '0;
          rstate_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d  = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rstate_d = R_STOP;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d   = '0;
          rstate_d = R_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_e     lstate_q, lstate_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    stage_q [16];
  logic [7:0]    stage_d [16];
  logic [7:0]    mem_q   [16];
  logic [7:0]    mem_d   [16];
  logic [7:0]    csum_total;

  // Loader registers, staging buffer and the committed program store.
  always_ff @(posedge clk) begin
    if (rst) begin
      lstate_q <= L_IDLE;
      idx_q    <= '0;
      sum_q    <= '0;
      tcnt_q   <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        stage_q[i] <= '0;
        mem_q[i]   <= '0;
      end
    end else begin
      lstate_q <= lstate_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      tcnt_q   <= tcnt_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      stage_q  <= stage_d;
      mem_q    <= mem_d;
    end
  end

  // Loader next state: sync hunt, staging, checksum commit, abort on error/timeout.
  always_comb begin
    lstate_d   = lstate_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    tcnt_d     = tcnt_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    stage_d    = stage_q;
    mem_d      = mem_q;
    csum_total = sum_q + rx_byte_q;
    unique case (lstate_q)
      L_IDLE: begin
        if (byte_valid_q && rx_byte_q == SYNC_BYTE) begin
          err_d    = 1'b0;
          idx_d    = '0;
          sum_d    = '0;
          tcnt_d   = '0;
          hold_d   = 1'b1;
          lstate_d = L_DATA;
        end
      end
      L_DATA, L_CSUM: begin
        if (frame_err_q) begin
          err_d    = 1'b1;
          hold_d   = 1'b0;
          lstate_d = L_IDLE;
        end else if (byte_valid_q) begin
          // A byte arriving on the expiry cycle still counts: it resets the timer.
          tcnt_d = '0;
          if (lstate_q == L_DATA) begin
            stage_d[idx_q] = rx_byte_q;
            sum_d          = sum_q + rx_byte_q;
            idx_d          = idx_q + 4'd1;
            if (idx_q == 4'd15) lstate_d = L_CSUM;
          end else begin
            if (csum_total == 8'h00) begin
              mem_d  = stage_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            hold_d   = 1'b0;
            lstate_d = L_IDLE;
          end
        end else if (tcnt_q == TO_LAST) begin
          err_d    = 1'b1;
          hold_d   = 1'b0;
          lstate_d = L_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: lstate_d = L_IDLE;
    endcase
  end

  assign rd_data   = mem_q[rd_addr];
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
